// File: rtl/winddir_pkg.sv
// Shared definitions for the wind-speed averaging path.
// Contents:
//   MINLOG2_DEF / MAXLOG2_DEF : default bounds of the log2 averaging length
//   SPEED_FRAC_BITS           : fractional bits of the speed sample format
//   avg_state_t               : sequencer state encoding
//   clamp_len()               : clamps a requested log2 length into [lo, hi]
package winddir_pkg;

    localparam int MINLOG2_DEF     = 6;
    localparam int MAXLOG2_DEF     = 11;
    localparam int SPEED_FRAC_BITS = 10;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RD   = 2'd1,
        ST_UPD  = 2'd2,
        ST_OUT  = 2'd3
    } avg_state_t;

    function automatic logic [3:0] clamp_len(
        input logic [3:0] req,
        input logic [3:0] lo,
        input logic [3:0] hi
    );
        logic [3:0] res;
        if (req < lo) begin
            res = lo;
        end else if (req > hi) begin
            res = hi;
        end else begin
            res = req;
        end
        return res;
    endfunction

endpackage

// File: rtl/sample_ram.sv
// Single-port synchronous sample RAM holding the averaging history of all
// channels. One-cycle read latency; a write cycle leaves rdata unchanged.
// Contents are not reset.
// Ports:
//   clock  in   system clock
//   we     in   write enable (write takes priority over read)
//   addr   in   word address
//   wdata  in   write data
//   rdata  out  registered read data, valid the cycle after the read
module sample_ram #(
    parameter int DW    = 16,
    parameter int AW    = 12,
    parameter int DEPTH = 4096
) (
    input  logic          clock,
    input  logic          we,
    input  logic [AW-1:0] addr,
    input  logic [DW-1:0] wdata,
    output logic [DW-1:0] rdata
);

    logic [DW-1:0] mem_r [DEPTH];

    // Storage array: write when enabled, otherwise register the read word.
    always_ff @(posedge clock) begin
        if (we) begin
            mem_r[addr] <= wdata;
        end else begin
            rdata <= mem_r[addr];
        end
    end

endmodule

// File: rtl/wind_speed_avg.sv
// Multi-channel moving-average filter for wind-speed samples.
// Each channel averages its last 2^L samples, L = clamp(meanlen) sampled at
// each accepted din_en. Channels share one adder and one RAM and are
// processed sequentially (RD/UPD per channel), then all averages are
// published together in OUT.
// Ports:
//   clock      in   system clock
//   reset      in   synchronous active-low reset
//   din_en     in   one-clock strobe, din carries one sample per channel
//   din        in   packed signed samples, channel k = din[k*DW +: DW]
//   meanlen    in   requested log2 averaging length
//   dout       out  packed signed averages (same packing as din)
//   dout_en    out  one-clock strobe when dout updates
//   dout_full  out  averaging window completely filled since last flush
//   overrun    out  sticky: din_en arrived while a sample was in progress
module wind_speed_avg
    import winddir_pkg::*;
#(
    parameter int NCH     = 2,
    parameter int DW      = 16,
    parameter int MINLOG2 = MINLOG2_DEF,
    parameter int MAXLOG2 = MAXLOG2_DEF
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              din_en,
    input  logic [NCH*DW-1:0] din,
    input  logic [3:0]        meanlen,
    output logic [NCH*DW-1:0] dout,
    output logic              dout_en,
    output logic              dout_full,
    output logic              overrun
);

    // Accumulator holds a full window sum of 2^MAXLOG2 samples without overflow.
    localparam int AW  = DW + MAXLOG2;
    localparam int CHW = (NCH > 1) ? $clog2(NCH) : 1;
    localparam int RAW = CHW + MAXLOG2;
    localparam int DEPTH = NCH * (2 ** MAXLOG2);
    localparam int FW  = MAXLOG2 + 1;

    avg_state_t            state_r;
    logic [CHW-1:0]        ch_r;
    logic [MAXLOG2-1:0]    wptr_r;
    logic [FW-1:0]         fill_r;
    logic [3:0]            len_r;
    logic [NCH*DW-1:0]     din_r;
    logic signed [AW-1:0]  acc_r [NCH];
    logic [NCH*DW-1:0]     dout_r;
    logic                  dout_en_r;
    logic                  dout_full_r;
    logic                  overrun_r;

    logic [3:0]            len_in_s;
    logic [FW-1:0]         win_s;
    logic [FW-1:0]         win_m1_s;
    logic                  window_full_s;
    logic [FW-1:0]         fill_next_s;
    logic [MAXLOG2-1:0]    wptr_next_s;
    logic [RAW-1:0]        ram_addr_s;
    logic                  ram_we_s;
    logic [DW-1:0]         ram_wdata_s;
    logic [DW-1:0]         ram_q_s;
    logic [DW-1:0]         old_s;
    logic signed [AW-1:0]  acc_upd_s;
    logic [NCH*DW-1:0]     mean_s;

    assign len_in_s = clamp_len(meanlen, 4'(MINLOG2), 4'(MAXLOG2));

    // Window bookkeeping: window size, wrapped write pointer and next fill level.
    always_comb begin
        win_s         = {{(FW-1){1'b0}}, 1'b1} << len_r;
        win_m1_s      = win_s - FW'(1);
        window_full_s = (fill_r == win_s);
        if (window_full_s) begin
            fill_next_s = win_s;
        end else begin
            fill_next_s = fill_r + FW'(1);
        end
        wptr_next_s   = (wptr_r + MAXLOG2'(1)) & win_m1_s[MAXLOG2-1:0];
    end

    // Shared datapath: RAM access for the current channel and its accumulator update.
    always_comb begin
        ram_addr_s  = {ch_r, wptr_r};
        ram_we_s    = (state_r == ST_UPD);
        ram_wdata_s = din_r[int'(ch_r) * DW +: DW];
        // Until the window is full the slot being overwritten holds no live sample.
        if (window_full_s) begin
            old_s = ram_q_s;
        end else begin
            old_s = {DW{1'b0}};
        end
        // Wraps modulo 2^AW; the true result always fits, so the sum stays exact.
        acc_upd_s = acc_r[ch_r]
                  + $signed({{MAXLOG2{ram_wdata_s[DW-1]}}, ram_wdata_s})
                  - $signed({{MAXLOG2{old_s[DW-1]}}, old_s});
    end

    // Per-channel mean: arithmetic shift floors toward minus infinity.
    always_comb begin
        logic signed [AW-1:0] sh_v;
        mean_s = {(NCH*DW){1'b0}};
        for (int k = 0; k < NCH; k++) begin
            sh_v = acc_r[k] >>> len_r;
            mean_s[k*DW +: DW] = sh_v[DW-1:0];
        end
    end

    sample_ram #(
        .DW    (DW),
        .AW    (RAW),
        .DEPTH (DEPTH)
    ) u_ram (
        .clock (clock),
        .we    (ram_we_s),
        .addr  (ram_addr_s),
        .wdata (ram_wdata_s),
        .rdata (ram_q_s)
    );

    // Sequencer, accumulators, counters and output registers.
    always_ff @(posedge clock) begin
        if (!reset) begin
            state_r     <= ST_IDLE;
            ch_r        <= '0;
            wptr_r      <= '0;
            fill_r      <= '0;
            len_r       <= 4'(MINLOG2);
            din_r       <= '0;
            dout_r      <= '0;
            dout_en_r   <= 1'b0;
            dout_full_r <= 1'b0;
            overrun_r   <= 1'b0;
            for (int k = 0; k < NCH; k++) begin
                acc_r[k] <= '0;
            end
        end else begin
            dout_en_r <= 1'b0;
            // A strobe outside IDLE (including during OUT) is dropped and flagged.
            if (din_en && (state_r != ST_IDLE)) begin
                overrun_r <= 1'b1;
            end
            case (state_r)
                ST_IDLE: begin
                    if (din_en) begin
                        din_r   <= din;
                        len_r   <= len_in_s;
                        ch_r    <= '0;
                        state_r <= ST_RD;
                        // New length: the accepted sample starts a fresh window.
                        if (len_in_s != len_r) begin
                            wptr_r      <= '0;
                            fill_r      <= '0;
                            dout_full_r <= 1'b0;
                            for (int k = 0; k < NCH; k++) begin
                                acc_r[k] <= '0;
                            end
                        end
                    end
                end
                ST_RD: begin
                    state_r <= ST_UPD;
                end
                ST_UPD: begin
                    acc_r[ch_r] <= acc_upd_s;
                    if (ch_r == CHW'(NCH - 1)) begin
                        state_r <= ST_OUT;
                    end else begin
                        ch_r    <= ch_r + CHW'(1);
                        state_r <= ST_RD;
                    end
                end
                ST_OUT: begin
                    dout_r      <= mean_s;
                    dout_en_r   <= 1'b1;
                    wptr_r      <= wptr_next_s;
                    fill_r      <= fill_next_s;
                    dout_full_r <= (fill_next_s == win_s);
                    state_r     <= ST_IDLE;
                end
                default: begin
                    state_r <= ST_IDLE;
                end
            endcase
        end
    end

    assign dout      = dout_r;
    assign dout_en   = dout_en_r;
    assign dout_full = dout_full_r;
    assign overrun   = overrun_r;

endmodule

// File: tb/tb_wind_speed_avg.sv
// Directed bench for wind_speed_avg with NCH=2, DW=16, MINLOG2=6, MAXLOG2=11.
module tb_wind_speed_avg;

    localparam int NCH = 2;
    localparam int DW  = 16;

    logic              clock = 1'b0;
    logic              reset;
    logic              din_en;
    logic [NCH*DW-1:0] din;
    logic [3:0]        meanlen;
    logic [NCH*DW-1:0] dout;
    logic              dout_en;
    logic              dout_full;
    logic              overrun;

    int tests = 0;
    int fails = 0;

    always #5 clock = ~clock;

    wind_speed_avg #(
        .NCH     (NCH),
        .DW      (DW),
        .MINLOG2 (6),
        .MAXLOG2 (11)
    ) dut (
        .clock     (clock),
        .reset     (reset),
        .din_en    (din_en),
        .din       (din),
        .meanlen   (meanlen),
        .dout      (dout),
        .dout_en   (dout_en),
        .dout_full (dout_full),
        .overrun   (overrun)
    );

    function automatic int ch_out(input int k);
        logic signed [DW-1:0] v;
        v = dout[k*DW +: DW];
        return int'(v);
    endfunction

    task automatic chk(input string tag, input int got, input int exp);
        tests++;
        assert (got === exp) else begin
            fails++;
            $error("FAIL %s: observed %0d expected %0d", tag, got, exp);
        end
    endtask

    // One accepted sample: checks latency, both channel averages and dout_full.
    task automatic send(input int d0, input int d1, input logic [3:0] ml,
                        input int gap, input int e0, input int e1,
                        input int efull, input string tag);
        int n;
        @(negedge clock);
        din_en  = 1'b1;
        din     = {16'(d1), 16'(d0)};
        meanlen = ml;
        @(posedge clock); #1;
        din_en  = 1'b0;
        n = 0;
        while (dout_en !== 1'b1 && n < 20) begin
            @(posedge clock); #1;
            n++;
        end
        chk({tag, "_lat"}, n, 5);
        chk({tag, "_ch0"}, ch_out(0), e0);
        chk({tag, "_ch1"}, ch_out(1), e1);
        chk({tag, "_full"}, int'(dout_full), efull);
        for (int g = 0; g < gap; g++) begin
            @(posedge clock); #1;
            if (g == 0) chk({tag, "_pulse"}, int'(dout_en), 0);
        end
    endtask

    initial begin
        int cnt;
        int v0;
        int v1;

        // Reset held 3 clocks with a strobe present: nothing must come out.
        reset   = 1'b0;
        din_en  = 1'b1;
        din     = {16'sd100, 16'sd100};
        meanlen = 4'd6;
        for (int i = 0; i < 3; i++) begin
            @(posedge clock); #1;
            chk("rst_douten", int'(dout_en), 0);
        end
        chk("rst_dout", int'(dout), 0);
        chk("rst_full", int'(dout_full), 0);
        chk("rst_ovr", int'(overrun), 0);
        @(negedge clock);
        din_en = 1'b0;
        reset  = 1'b1;

        // Constant 1024/-1024 at L=6, one sample every 20 clocks.
        for (int k = 1; k <= 66; k++) begin
            if (k <= 64) send(1024, -1024, 4'd6, 14, 16 * k, -16 * k, (k == 64) ? 1 : 0, "const");
            else         send(1024, -1024, 4'd6, 14, 1024, -1024, 1, "const_full");
        end
        chk("const_ovr", int'(overrun), 0);

        // Length change to L=8: flush, then full after 256 samples.
        for (int k = 1; k <= 257; k++) begin
            if (k <= 256) send(1024, -1024, 4'd8, 0, 4 * k, -4 * k, (k == 256) ? 1 : 0, "len8");
            else          send(1024, -1024, 4'd8, 0, 1024, -1024, 1, "len8_full");
        end

        // Floor rounding at L=6: -1 then zeros gives -1 for a whole window.
        send(-1, 1, 4'd6, 0, -1, 0, 0, "floor_first");
        for (int k = 2; k <= 65; k++) begin
            if (k <= 64) send(0, 0, 4'd6, 0, -1, 0, (k == 64) ? 1 : 0, "floor");
            else         send(0, 0, 4'd6, 0, 0, 0, 1, "floor_drop");
        end

        // meanlen=15 clamps to 11: full after 2048 samples.
        for (int k = 1; k <= 2049; k++) begin
            if (k <= 2048) send(2048, -2048, 4'd15, 0, k, -k, (k == 2048) ? 1 : 0, "clamp_hi");
            else           send(2048, -2048, 4'd15, 0, 2048, -2048, 1, "clamp_hi_full");
        end

        // meanlen=3 clamps to 6: full after 64 samples.
        for (int k = 1; k <= 64; k++) begin
            send(64, -64, 4'd3, 0, k, -k, (k == 64) ? 1 : 0, "clamp_lo");
        end

        // Overrun: second strobe two clocks after an accepted one.
        @(negedge clock);
        din_en = 1'b1;
        din    = {-16'sd64, 16'sd64};
        @(posedge clock); #1;
        din_en = 1'b0;
        @(posedge clock); #1;
        @(negedge clock);
        din_en = 1'b1;
        din    = {-16'sd5000, 16'sd5000};
        @(posedge clock); #1;
        din_en = 1'b0;
        cnt = 0;
        v0  = 0;
        v1  = 0;
        for (int i = 0; i < 15; i++) begin
            @(posedge clock); #1;
            if (dout_en === 1'b1) begin
                cnt++;
                v0 = ch_out(0);
                v1 = ch_out(1);
            end
        end
        chk("ovr_count", cnt, 1);
        chk("ovr_ch0", v0, 64);
        chk("ovr_ch1", v1, -64);
        chk("ovr_flag", int'(overrun), 1);
        send(64, -64, 4'd3, 0, 64, -64, 1, "ovr_after");
        chk("ovr_sticky", int'(overrun), 1);

        // Reset in the middle of a sample: no output, all state back to reset.
        @(negedge clock);
        din_en = 1'b1;
        din    = {16'sd300, 16'sd300};
        @(posedge clock); #1;
        din_en = 1'b0;
        @(negedge clock);
        reset = 1'b0;
        @(posedge clock); #1;
        @(negedge clock);
        reset = 1'b1;
        cnt = 0;
        for (int i = 0; i < 10; i++) begin
            @(posedge clock); #1;
            if (dout_en === 1'b1) cnt++;
        end
        chk("midrst_douten", cnt, 0);
        chk("midrst_dout", int'(dout), 0);
        chk("midrst_full", int'(dout_full), 0);
        chk("midrst_ovr", int'(overrun), 0);
        send(64, -64, 4'd6, 0, 1, -1, 0, "midrst_next");

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
